// File: rtl/vga_pkg.sv
// Shared VGA timing types and helpers for the timing generator and receiver.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vga_pkg;

  // Receiver lock state.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vga_state_e;

  // Total clocks per line (or lines per frame) from the four timing segments.
  function automatic int vga_total(input int pulse, input int back, input int active,
                                   input int front);
    return pulse + back + active + front;
  endfunction

  // Offset of the first active pixel (or line) from the sync pulse start.
  function automatic int vga_active_start(input int pulse, input int back);
    return pulse + back;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input register plus rise/fall detector for one sync line.
// Latency: one register on sig_i; rise_o/fall_o are decoded from the registered copy.
// Backpressure: none; samples every clock.
module vga_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;
  logic sig_d;
  logic prev_q;
  logic prev_d;

  // Next values: fresh pin sample, and one clock of history of the registered copy.
  always_comb begin
    sig_d  = sig_i;
    prev_d = sig_q;
  end

  // Sample and history registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sig_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sig_q & ~prev_q;
  assign fall_o = ~sig_q & prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: recovers pixel coordinates, checks timing, raises lock.
// Latency: 2 clocks from pins to x/y/rgb/pix_v; frame/err/locked follow the registered edges.
// Backpressure: none; the source is free-running and sampled every clock.
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int width_p              = 800,
  parameter int height_p             = 600,
  parameter int h_sync_pulse_p       = 72,
  parameter int h_sync_back_porch_p  = 128,
  parameter int h_sync_front_porch_p = 24,
  parameter int v_sync_pulse_p       = 2,
  parameter int v_sync_back_porch_p  = 22,
  parameter int v_sync_front_porch_p = 1,
  parameter int bit_depth_p          = 8,
  parameter int lock_frames_p        = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          hs_i,
  input  logic                          vs_i,
  input  logic [bit_depth_p-1:0]        r_i,
  input  logic [bit_depth_p-1:0]        g_i,
  input  logic [bit_depth_p-1:0]        b_i,
  output logic [$clog2(width_p)-1:0]    x_o,
  output logic [$clog2(height_p)-1:0]   y_o,
  output logic                          pix_v_o,
  output logic [bit_depth_p-1:0]        r_o,
  output logic [bit_depth_p-1:0]        g_o,
  output logic [bit_depth_p-1:0]        b_o,
  output logic                          frame_o,
  output logic                          locked_o,
  output logic                          err_o
);

  localparam int ROW     = vga_total(h_sync_pulse_p, h_sync_back_porch_p, width_p,
                                     h_sync_front_porch_p);
  localparam int COL     = vga_total(v_sync_pulse_p, v_sync_back_porch_p, height_p,
                                     v_sync_front_porch_p);
  localparam int H_START = vga_active_start(h_sync_pulse_p, h_sync_back_porch_p);
  localparam int V_START = vga_active_start(v_sync_pulse_p, v_sync_back_porch_p);

  // Counters need one code above the last legal value so saturation is visible.
  localparam int HW = $clog2(ROW + 1);
  localparam int VW = $clog2(COL + 1);
  localparam int XW = $clog2(width_p);
  localparam int YW = $clog2(height_p);
  localparam int CW = $clog2(lock_frames_p + 1);
  localparam int BW = bit_depth_p;

  localparam logic [HW-1:0] ROW_C       = HW'(ROW);
  localparam logic [HW-1:0] ROW_M1_C    = HW'(ROW - 1);
  localparam logic [HW-1:0] HPULSE_M1_C = HW'(h_sync_pulse_p - 1);
  localparam logic [HW-1:0] H_START_C   = HW'(H_START);
  localparam logic [HW-1:0] H_END_C     = HW'(H_START + width_p);
  localparam logic [VW-1:0] COL_C       = VW'(COL);
  localparam logic [VW-1:0] COL_M1_C    = VW'(COL - 1);
  localparam logic [VW-1:0] VPULSE_C    = VW'(v_sync_pulse_p);
  localparam logic [VW-1:0] V_START_C   = VW'(V_START);
  localparam logic [VW-1:0] V_END_C     = VW'(V_START + height_p);
  localparam logic [CW-1:0] LOCK_C      = CW'(lock_frames_p);

  // Registered sync edges.
  logic hs_rise;
  logic hs_fall;
  logic vs_rise;
  logic vs_fall;

  // Input register for colour, aligned with the registered sync copies.
  logic [BW-1:0] r_in_q, r_in_d;
  logic [BW-1:0] g_in_q, g_in_d;
  logic [BW-1:0] b_in_q, b_in_d;

  // Position counters: h_cnt_q/v_cnt_q describe the sample now leaving the input register.
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  // Lock state machine.
  vga_state_e    state_q, state_d;
  logic [CW-1:0] clean_q, clean_d;
  logic          checking;
  logic          viol_raw;
  logic          viol;

  // Output stage.
  logic          h_act;
  logic          v_act;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pix_v_q, pix_v_d;
  logic [BW-1:0] r_out_q, r_out_d;
  logic [BW-1:0] g_out_q, g_out_d;
  logic [BW-1:0] b_out_q, b_out_d;
  logic          frame_q, frame_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

  vga_sync_edge u_hs_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (hs_i),
    .rise_o  (hs_rise),
    .fall_o  (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (vs_i),
    .rise_o  (vs_rise),
    .fall_o  (vs_fall)
  );

  // Colour input register and horizontal/vertical position counters with saturation.
  always_comb begin
    r_in_d = r_i;
    g_in_d = g_i;
    b_in_d = b_i;

    h_cnt_d = h_cnt_q;
    if (hs_rise) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != ROW_C) begin
      h_cnt_d = h_cnt_q + HW'(1);
    end

    v_cnt_d = v_cnt_q;
    if (vs_rise) begin
      v_cnt_d = '0;
    end else if (hs_rise && (v_cnt_q != COL_C)) begin
      v_cnt_d = v_cnt_q + VW'(1);
    end
  end

  // Timing checks; only meaningful once a frame start has been seen.
  always_comb begin
    checking = (state_q == MEASURE) || (state_q == LOCKED);
    viol_raw = 1'b0;
    // A line must close exactly one clock after count ROW-1.
    if (hs_rise && (h_cnt_q != ROW_M1_C)) viol_raw = 1'b1;
    // The hs pulse must last exactly h_sync_pulse_p clocks.
    if (hs_fall && (h_cnt_q != HPULSE_M1_C)) viol_raw = 1'b1;
    // Frame starts must line up with a line start and close a full frame.
    if (vs_rise && !hs_rise) viol_raw = 1'b1;
    if (vs_rise && (v_cnt_q != COL_M1_C)) viol_raw = 1'b1;
    // The vs pulse must end at the start of line v_sync_pulse_p.
    if (vs_fall && !(hs_rise && (v_cnt_d == VPULSE_C))) viol_raw = 1'b1;
    // Any attempt to count past the end of a line or frame.
    if ((h_cnt_q == ROW_C) && !hs_rise) viol_raw = 1'b1;
    if ((v_cnt_q == COL_C) && hs_rise && !vs_rise) viol_raw = 1'b1;
    viol = checking && viol_raw;
  end

  // Lock FSM next state; a violation outranks a lock-completing frame edge.
  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = MEASURE;
          clean_d = '0;
        end
      end
      MEASURE: begin
        if (viol) begin
          err_d   = 1'b1;
          state_d = SEARCH;
          clean_d = '0;
        end else if (vs_rise) begin
          clean_d = clean_q + CW'(1);
          if (clean_d == LOCK_C) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) begin
          err_d   = 1'b1;
          state_d = SEARCH;
          clean_d = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        clean_d = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SEARCH;
      clean_q <= '0;
    end else begin
      state_q <= state_d;
      clean_q <= clean_d;
    end
  end

  // Output stage: active-region decode, coordinate capture, colour and status pulses.
  always_comb begin
    h_act   = (h_cnt_d >= H_START_C) && (h_cnt_d < H_END_C);
    v_act   = (v_cnt_d >= V_START_C) && (v_cnt_d < V_END_C);
    // Only pixels seen while already locked and clean are reported.
    pix_v_d = h_act && v_act && (state_q == LOCKED) && !viol;
    x_d     = x_q;
    y_d     = y_q;
    if (pix_v_d) begin
      x_d = XW'(h_cnt_d - H_START_C);
      y_d = YW'(v_cnt_d - V_START_C);
    end
    r_out_d  = r_in_q;
    g_out_d  = g_in_q;
    b_out_d  = b_in_q;
    frame_d  = vs_rise;
    locked_d = (state_q == LOCKED);
  end

  // Datapath and output registers, all cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_in_q   <= '0;
      g_in_q   <= '0;
      b_in_q   <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_v_q  <= 1'b0;
      r_out_q  <= '0;
      g_out_q  <= '0;
      b_out_q  <= '0;
      frame_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      r_in_q   <= r_in_d;
      g_in_q   <= g_in_d;
      b_in_q   <= b_in_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_v_q  <= pix_v_d;
      r_out_q  <= r_out_d;
      g_out_q  <= g_out_d;
      b_out_q  <= b_out_d;
      frame_q  <= frame_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign pix_v_o  = pix_v_q;
  assign r_o      = r_out_q;
  assign g_o      = g_out_q;
  assign b_o      = b_out_q;
  assign frame_o  = frame_q;
  assign locked_o = locked_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced timing mode (28 clocks x 14 lines).
// Latency: generator drives on negedge; outputs are sampled 1 time unit after negedge.
// Backpressure: none.
module tb_vga_sync_receiver;

  localparam int W   = 16;
  localparam int H   = 8;
  localparam int HP  = 4;
  localparam int HBP = 6;
  localparam int HFP = 2;
  localparam int VP  = 2;
  localparam int VBP = 3;
  localparam int VFP = 1;
  localparam int ROW = HP + HBP + W + HFP;  // 28
  localparam int COL = VP + VBP + H + VFP;  // 14

  logic       clk_i;
  logic       reset_i;
  logic       hs_i;
  logic       vs_i;
  logic [7:0] r_i;
  logic [7:0] g_i;
  logic [7:0] b_i;
  logic [3:0] x_o;
  logic [2:0] y_o;
  logic       pix_v_o;
  logic [7:0] r_o;
  logic [7:0] g_o;
  logic [7:0] b_o;
  logic       frame_o;
  logic       locked_o;
  logic       err_o;

  vga_sync_receiver #(
    .width_p              (W),
    .height_p             (H),
    .h_sync_pulse_p       (HP),
    .h_sync_back_porch_p  (HBP),
    .h_sync_front_porch_p (HFP),
    .v_sync_pulse_p       (VP),
    .v_sync_back_porch_p  (VBP),
    .v_sync_front_porch_p (VFP),
    .bit_depth_p          (8),
    .lock_frames_p        (2)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .hs_i     (hs_i),
    .vs_i     (vs_i),
    .r_i      (r_i),
    .g_i      (g_i),
    .b_i      (b_i),
    .x_o      (x_o),
    .y_o      (y_o),
    .pix_v_o  (pix_v_o),
    .r_o      (r_o),
    .g_o      (g_o),
    .b_o      (b_o),
    .frame_o  (frame_o),
    .locked_o (locked_o),
    .err_o    (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cmp_cnt = 0;
  int mis_cnt = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Generator state and fault requests.
  bit gen_run         = 1'b0;
  bit req_long_line   = 1'b0;
  bit req_short_hs    = 1'b0;
  bit req_short_frame = 1'b0;
  bit long_pending    = 1'b0;
  bit short_fr_pend   = 1'b0;
  bit short_hs_line   = 1'b0;
  int gh = 0, gv = 0;
  int ln_len = ROW, hs_len = HP, fr_lines = COL;
  int drv_h = -1, drv_v = -1;
  int mark_cyc = 0;

  // Monitor state.
  int   cyc = 0;
  int   frame_cnt = 0, err_cnt = 0, lock_rise_cnt = 0, pv_bad_cnt = 0;
  int   last_frame_cyc = 0, last_err_cyc = 0, lock_rise_cyc = 0, lock_fall_cyc = 0;
  logic locked_prev = 1'b0;

  // Each negedge: record DUT events first, then drive the next pixel of the timing generator.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (frame_o === 1'b1) begin frame_cnt++; last_frame_cyc = cyc; end
      if (err_o === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
      if (locked_o === 1'b1 && locked_prev !== 1'b1) begin
        lock_rise_cnt++;
        lock_rise_cyc = cyc;
      end
      if (locked_o !== 1'b1 && locked_prev === 1'b1) lock_fall_cyc = cyc;
      if (pix_v_o === 1'b1 && locked_o !== 1'b1) pv_bad_cnt++;
      locked_prev = locked_o;

      if (gen_run) begin
        if (gh == 0) begin
          if (long_pending) begin mark_cyc = cyc; long_pending = 1'b0; end
          ln_len = ROW;
          hs_len = HP;
          if (gv == 0) begin
            if (short_fr_pend) begin mark_cyc = cyc; short_fr_pend = 1'b0; end
            fr_lines = COL;
            if (req_short_frame) begin
              fr_lines = COL - 1; req_short_frame = 1'b0; short_fr_pend = 1'b1;
            end
          end
          if (req_long_line) begin
            ln_len = ROW + 1; req_long_line = 1'b0; long_pending = 1'b1;
          end
          if (req_short_hs) begin
            hs_len = HP - 1; req_short_hs = 1'b0; short_hs_line = 1'b1;
          end
        end
        if (short_hs_line && gh == hs_len) begin mark_cyc = cyc; short_hs_line = 1'b0; end
        hs_i  = (gh < hs_len);
        vs_i  = (gv < VP);
        r_i   = 8'(gh);
        g_i   = 8'(gv);
        b_i   = 8'(gh + gv);
        drv_h = gh;
        drv_v = gv;
        gh++;
        if (gh == ln_len) begin
          gh = 0;
          gv++;
          if (gv == fr_lines) gv = 0;
        end
      end
    end
  end

  // Wait until the generator has driven (h, v), then two more clocks so that pixel is at the outputs.
  task automatic probe(input int h, input int v);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(drv_h == h && drv_v == v) && n < 2000);
    chk_eq("probe_reach", drv_h * 100 + drv_v, h * 100 + v);
    tick();
    tick();
  endtask

  task automatic wait_lock(input string tag, input int limit);
    for (int i = 0; i < limit && locked_o !== 1'b1; i++) tick();
    chk_eq(tag, locked_o, 1);
  endtask

  task automatic wait_err(input string tag, input int base, input int limit);
    for (int i = 0; i < limit && err_cnt == base; i++) tick();
    chk_eq(tag, err_cnt - base, 1);
  endtask

  task automatic chk_all_zero();
    chk_eq("zero_x", x_o, 0);
    chk_eq("zero_y", y_o, 0);
    chk_eq("zero_pixv", pix_v_o, 0);
    chk_eq("zero_r", r_o, 0);
    chk_eq("zero_g", g_o, 0);
    chk_eq("zero_b", b_o, 0);
    chk_eq("zero_frame", frame_o, 0);
    chk_eq("zero_locked", locked_o, 0);
    chk_eq("zero_err", err_o, 0);
  endtask

  int base_err;
  int fr0;

  initial begin
    reset_i = 1'b1;
    hs_i    = 1'b0;
    vs_i    = 1'b0;
    r_i     = 8'h5a;
    g_i     = 8'ha5;
    b_i     = 8'h3c;
    repeat (3) tick();
    chk_all_zero();

    // Clean loopback from reset: lock one clock after the third frame pulse.
    reset_i = 1'b0;
    gen_run = 1'b1;
    wait_lock("lock_up", 3000);
    chk_eq("lock_frames", frame_cnt, 3);
    chk_eq("lock_latency", lock_rise_cyc - last_frame_cyc, 1);
    chk_eq("lock_no_err", err_cnt, 0);

    // Coordinates and colour at the active-region corners.
    probe(10, 5);
    chk_eq("first_px_v", pix_v_o, 1);
    chk_eq("first_px_x", x_o, 0);
    chk_eq("first_px_y", y_o, 0);
    probe(19, 10);
    chk_eq("mid_px_v", pix_v_o, 1);
    chk_eq("mid_px_x", x_o, 9);
    chk_eq("mid_px_y", y_o, 5);
    chk_eq("mid_px_r", r_o, 19);
    chk_eq("mid_px_g", g_o, 10);
    chk_eq("mid_px_b", b_o, 29);
    probe(26, 10);
    chk_eq("fporch_v", pix_v_o, 0);
    chk_eq("fporch_x_hold", x_o, 15);
    chk_eq("fporch_y_hold", y_o, 5);
    chk_eq("fporch_r", r_o, 26);
    chk_eq("fporch_b", b_o, 36);
    probe(12, 4);
    chk_eq("vporch_v", pix_v_o, 0);
    chk_eq("vporch_x_hold", x_o, 15);
    chk_eq("vporch_y_hold", y_o, 7);
    chk_eq("vporch_g", g_o, 4);

    // One line stretched by a clock while locked.
    base_err = err_cnt;
    req_long_line = 1'b1;
    wait_err("long_err", base_err, 200);
    chk_eq("long_err_at", last_err_cyc - mark_cyc, 2);
    tick();
    chk_eq("long_unlocked", locked_o, 0);
    chk_eq("long_fall_at", lock_fall_cyc - last_err_cyc, 1);
    fr0 = frame_cnt;
    wait_lock("long_relock", 2500);
    chk_eq("long_relock_frames", frame_cnt - fr0, 3);
    chk_eq("long_relock_lat", lock_rise_cyc - last_frame_cyc, 1);
    chk_eq("long_err_once", err_cnt - base_err, 1);

    // hs pulse one clock short while locked.
    base_err = err_cnt;
    req_short_hs = 1'b1;
    wait_err("shs_err", base_err, 200);
    chk_eq("shs_err_at", last_err_cyc - mark_cyc, 2);
    tick();
    chk_eq("shs_unlocked", locked_o, 0);

    // Next frame starts MEASURE and is one line short.
    base_err = err_cnt;
    req_short_frame = 1'b1;
    wait_err("sfr_err", base_err, 1500);
    chk_eq("sfr_err_at", last_err_cyc - mark_cyc, 2);
    chk_eq("sfr_locked", locked_o, 0);
    chk_eq("sfr_no_lock", lock_rise_cnt, 2);
    fr0 = frame_cnt;
    wait_lock("sfr_relock", 2500);
    chk_eq("sfr_relock_frames", frame_cnt - fr0, 3);
    chk_eq("sfr_lock_count", lock_rise_cnt, 3);

    // Asynchronous reset mid-line while locked.
    probe(15, 8);
    chk_eq("pre_rst_pixv", pix_v_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk_all_zero();
    tick();
    tick();
    reset_i = 1'b0;
    fr0 = frame_cnt;
    wait_lock("rst_relock", 2500);
    chk_eq("rst_relock_frames", frame_cnt - fr0, 3);
    chk_eq("rst_lock_count", lock_rise_cnt, 4);
    chk_eq("pixv_only_locked", pv_bad_cnt, 0);
    chk_eq("total_errs", err_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
